// File: rtl/sensor_spi_pkg.sv
// sensor_spi_pkg: framing constants and FSM encoding shared by the sensor SPI master and responder
package sensor_spi_pkg;
  localparam int ADDR_BITS = 8;
  localparam int DATA_BITS = 8;
  localparam logic [7:0] READ_OOR_VAL = 8'h00;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_COMMIT,
    ST_RDATA,
    ST_DONE,
    ST_ERR
  } spi_state_e;
endpackage

// File: rtl/sensor_spi_responder_if.sv
// sensor_spi_responder_if: 4-wire sensor SPI bundle with master and slave views
interface sensor_spi_responder_if;
  logic spi_clk;
  logic spi_write;
  logic spi_read;
  logic spi_in;
  logic spi_out;
  modport master (output spi_clk, spi_write, spi_read, spi_in, input spi_out);
  modport slave (input spi_clk, spi_write, spi_read, spi_in, output spi_out);
endinterface

// File: rtl/spi_in_sync.sv
// spi_in_sync: synchronizes the SPI inputs into clk_fix and detects spi_clk edges
module spi_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_fix,
  input  logic rst_fix_n,
  input  logic spi_clk,
  input  logic spi_write,
  input  logic spi_read,
  input  logic spi_in,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic wr_en_s,
  output logic rd_en_s,
  output logic sdi_s
);
  localparam int L = SYNC_STAGES - 1;
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] sync_d [SYNC_STAGES];
  logic sclk_dly_q, sclk_dly_d;
  always_comb begin
    sync_d[0] = {spi_clk, spi_write, spi_read, spi_in};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    sclk_dly_d = sync_q[L][3];
  end
  always_ff @(posedge clk_fix or negedge rst_fix_n) begin
    if (!rst_fix_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      sclk_dly_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      sclk_dly_q <= sclk_dly_d;
    end
  end
  assign sclk_rise = sync_q[L][3] & ~sclk_dly_q;
  assign sclk_fall = ~sync_q[L][3] & sclk_dly_q;
  assign wr_en_s   = sync_q[L][2];
  assign rd_en_s   = sync_q[L][1];
  assign sdi_s     = sync_q[L][0];
endmodule

// File: rtl/sensor_spi_responder.sv
// sensor_spi_responder: SPI slave that decodes write/read frames against an 8-bit register bank
module sensor_spi_responder
  import sensor_spi_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter logic [7:0] RST_VAL = 8'h00,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_fix,
  input  logic rst_fix_n,
  sensor_spi_responder_if.slave spi,
  output logic [NUM_REGS*8-1:0] reg_bank,
  output logic reg_wr_pulse,
  output logic [7:0] reg_wr_addr,
  output logic frame_err
);
  logic sclk_rise, sclk_fall, wr_en_s, rd_en_s, sdi_s;
  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_fix   (clk_fix),
    .rst_fix_n (rst_fix_n),
    .spi_clk   (spi.spi_clk),
    .spi_write (spi.spi_write),
    .spi_read  (spi.spi_read),
    .spi_in    (spi.spi_in),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .wr_en_s   (wr_en_s),
    .rd_en_s   (rd_en_s),
    .sdi_s     (sdi_s)
  );
  spi_state_e state_q, state_d;
  logic is_wr_q, is_wr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] addr_q, addr_d;
  logic load_q, load_d;
  logic spi_out_q, spi_out_d;
  logic reg_wr_pulse_q, reg_wr_pulse_d;
  logic [7:0] reg_wr_addr_q, reg_wr_addr_d;
  logic frame_err_q, frame_err_d;
  logic [7:0] regs_q [NUM_REGS];
  logic [7:0] regs_d [NUM_REGS];
  logic en;
  logic [7:0] rd_val;
  logic [7:0] shift_in;
  always_comb begin
    state_d        = state_q;
    is_wr_d        = is_wr_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    addr_d         = addr_q;
    load_d         = load_q;
    spi_out_d      = spi_out_q;
    reg_wr_pulse_d = 1'b0;
    reg_wr_addr_d  = reg_wr_addr_q;
    frame_err_d    = 1'b0;
    regs_d         = regs_q;
    en             = is_wr_q ? wr_en_s : rd_en_s;
    shift_in       = {shift_q[6:0], sdi_s};
    rd_val         = READ_OOR_VAL;
    for (int i = 0; i < NUM_REGS; i++) if (addr_q == 8'(i)) rd_val = regs_q[i];
    if ((state_q == ST_ADDR || state_q == ST_WDATA || state_q == ST_RDATA) && !en) begin
      frame_err_d = 1'b1;
      spi_out_d   = 1'b0;
      load_d      = 1'b0;
      state_d     = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          spi_out_d = 1'b0;
          if (wr_en_s && rd_en_s) begin
            frame_err_d = 1'b1;
            state_d     = ST_ERR;
          end else if (wr_en_s || rd_en_s) begin
            bit_cnt_d = '0;
            is_wr_d   = wr_en_s;
            state_d   = ST_ADDR;
          end
        end
        ST_ADDR: if (sclk_rise) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(ADDR_BITS - 1)) begin
            addr_d    = shift_in;
            bit_cnt_d = '0;
            load_d    = !is_wr_q;
            state_d   = is_wr_q ? ST_WDATA : ST_RDATA;
          end
        end
        ST_WDATA: if (sclk_rise) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_q == 8'(i)) begin
              regs_d[i]      = shift_q;
              reg_wr_pulse_d = 1'b1;
              reg_wr_addr_d  = addr_q;
            end
          end
          state_d = ST_DONE;
        end
        ST_RDATA: begin
          // the fall right after the last address rise must not shift: MSB is sampled on the next rise
          if (load_q) begin
            shift_d   = rd_val;
            spi_out_d = rd_val[7];
            load_d    = 1'b0;
          end else if (sclk_fall && bit_cnt_q != 3'd0) begin
            shift_d   = {shift_q[6:0], 1'b0};
            spi_out_d = shift_q[6];
          end else if (sclk_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
              bit_cnt_d = '0;
              state_d   = ST_DONE;
            end
          end
        end
        ST_DONE: if (!en) begin
          spi_out_d = 1'b0;
          state_d   = ST_IDLE;
        end
        ST_ERR: if (!wr_en_s && !rd_en_s) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_fix or negedge rst_fix_n) begin
    if (!rst_fix_n) begin
      state_q        <= ST_IDLE;
      is_wr_q        <= 1'b0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      addr_q         <= '0;
      load_q         <= 1'b0;
      spi_out_q      <= 1'b0;
      reg_wr_pulse_q <= 1'b0;
      reg_wr_addr_q  <= '0;
      frame_err_q    <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RST_VAL;
    end else begin
      state_q        <= state_d;
      is_wr_q        <= is_wr_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      addr_q         <= addr_d;
      load_q         <= load_d;
      spi_out_q      <= spi_out_d;
      reg_wr_pulse_q <= reg_wr_pulse_d;
      reg_wr_addr_q  <= reg_wr_addr_d;
      frame_err_q    <= frame_err_d;
      regs_q         <= regs_d;
    end
  end
  always_comb begin
    reg_bank = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_bank[8*i +: 8] = regs_q[i];
  end
  assign spi.spi_out   = spi_out_q;
  assign reg_wr_pulse  = reg_wr_pulse_q;
  assign reg_wr_addr   = reg_wr_addr_q;
  assign frame_err     = frame_err_q;
endmodule

// File: tb/tb_sensor_spi_responder.sv
// tb_sensor_spi_responder: directed frames against sensor_spi_responder with spi_clk = clk_fix/10
module tb_sensor_spi_responder;
  localparam int NR = 32;
  logic clk_fix = 1'b0;
  logic rst_fix_n = 1'b0;
  logic [NR*8-1:0] reg_bank;
  logic reg_wr_pulse;
  logic [7:0] reg_wr_addr;
  logic frame_err;
  logic [NR*8-1:0] exp_bank;
  logic [7:0] got;
  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int err_cnt = 0;
  int wr_base, err_base;
  sensor_spi_responder_if spi();
  sensor_spi_responder #(.NUM_REGS(NR), .RST_VAL(8'h00), .SYNC_STAGES(2)) dut (
    .clk_fix      (clk_fix),
    .rst_fix_n    (rst_fix_n),
    .spi          (spi),
    .reg_bank     (reg_bank),
    .reg_wr_pulse (reg_wr_pulse),
    .reg_wr_addr  (reg_wr_addr),
    .frame_err    (frame_err)
  );
  always #5 clk_fix = ~clk_fix;
  always @(negedge clk_fix) begin
    if (reg_wr_pulse) wr_cnt++;
    if (frame_err) err_cnt++;
  end
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  task automatic half();
    repeat (5) @(negedge clk_fix);
  endtask
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      spi.spi_in = v[15-i];
      half();
      spi.spi_clk = 1'b1;
      half();
      spi.spi_clk = 1'b0;
    end
  endtask
  task automatic write_frame(input logic [7:0] a, input logic [7:0] d, input int n);
    spi.spi_write = 1'b1;
    half();
    send_bits({a, d}, n);
    half();
    spi.spi_write = 1'b0;
    repeat (10) @(negedge clk_fix);
  endtask
  task automatic read_frame(input logic [7:0] a, output logic [7:0] r);
    spi.spi_read = 1'b1;
    half();
    send_bits({a, 8'h00}, 8);
    for (int i = 0; i < 8; i++) begin
      half();
      r[7-i] = spi.spi_out;
      spi.spi_clk = 1'b1;
      half();
      spi.spi_clk = 1'b0;
    end
    half();
    spi.spi_read = 1'b0;
    repeat (10) @(negedge clk_fix);
  endtask
  initial begin
    spi.spi_clk = 1'b0;
    spi.spi_write = 1'b0;
    spi.spi_read = 1'b0;
    spi.spi_in = 1'b0;
    exp_bank = '0;
    repeat (3) @(negedge clk_fix);
    check("rst_spi_out", 256'(spi.spi_out), 256'(1'b0));
    check("rst_reg_bank", 256'(reg_bank), 256'(exp_bank));
    check("rst_wr_pulse", 256'(reg_wr_pulse), 256'(1'b0));
    check("rst_wr_addr", 256'(reg_wr_addr), 256'(8'h00));
    check("rst_frame_err", 256'(frame_err), 256'(1'b0));
    rst_fix_n = 1'b1;
    repeat (5) @(negedge clk_fix);
    wr_base = wr_cnt; err_base = err_cnt;
    write_frame(8'h05, 8'hA7, 16);
    exp_bank[47:40] = 8'hA7;
    check("w05_pulses", 256'(wr_cnt - wr_base), 256'(1));
    check("w05_wr_addr", 256'(reg_wr_addr), 256'(8'h05));
    check("w05_bank", 256'(reg_bank), 256'(exp_bank));
    check("w05_no_err", 256'(err_cnt - err_base), 256'(0));
    read_frame(8'h05, got);
    check("r05_data", 256'(got), 256'(8'hA7));
    check("r05_spi_out_idle", 256'(spi.spi_out), 256'(1'b0));
    wr_base = wr_cnt;
    write_frame(8'h40, 8'hFF, 16);
    check("w40_pulses", 256'(wr_cnt - wr_base), 256'(0));
    check("w40_bank", 256'(reg_bank), 256'(exp_bank));
    check("w40_wr_addr", 256'(reg_wr_addr), 256'(8'h05));
    read_frame(8'h40, got);
    check("r40_data", 256'(got), 256'(8'h00));
    wr_base = wr_cnt; err_base = err_cnt;
    write_frame(8'h03, 8'h99, 11);
    check("abort_err", 256'(err_cnt - err_base), 256'(1));
    check("abort_pulses", 256'(wr_cnt - wr_base), 256'(0));
    check("abort_bank", 256'(reg_bank), 256'(exp_bank));
    wr_base = wr_cnt;
    write_frame(8'h03, 8'h3C, 16);
    exp_bank[31:24] = 8'h3C;
    check("w03_pulses", 256'(wr_cnt - wr_base), 256'(1));
    check("w03_bank", 256'(reg_bank), 256'(exp_bank));
    read_frame(8'h03, got);
    check("r03_data", 256'(got), 256'(8'h3C));
    wr_base = wr_cnt; err_base = err_cnt;
    spi.spi_write = 1'b1;
    spi.spi_read = 1'b1;
    half();
    send_bits(16'hFFFF, 16);
    half();
    spi.spi_write = 1'b0;
    spi.spi_read = 1'b0;
    repeat (10) @(negedge clk_fix);
    check("both_err", 256'(err_cnt - err_base), 256'(1));
    check("both_pulses", 256'(wr_cnt - wr_base), 256'(0));
    check("both_bank", 256'(reg_bank), 256'(exp_bank));
    read_frame(8'h00, got);
    check("r00_data", 256'(got), 256'(8'h00));
    write_frame(8'h01, 8'h55, 16);
    exp_bank[15:8] = 8'h55;
    check("w01_bank", 256'(reg_bank), 256'(exp_bank));
    spi.spi_write = 1'b1;
    half();
    send_bits({8'h01, 8'hAA}, 11);
    rst_fix_n = 1'b0;
    repeat (2) @(negedge clk_fix);
    check("midrst_bank", 256'(reg_bank), 256'(0));
    check("midrst_spi_out", 256'(spi.spi_out), 256'(1'b0));
    spi.spi_write = 1'b0;
    repeat (3) @(negedge clk_fix);
    rst_fix_n = 1'b1;
    repeat (10) @(negedge clk_fix);
    read_frame(8'h01, got);
    check("r01_after_rst", 256'(got), 256'(8'h00));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sensor_spi_responder.md
Name: sensor_spi_responder

Overview:
Synthesizable sensor-side SPI register responder: the slave end of the 4-wire sensor SPI (spi_clk/spi_write/spi_read/spi_in in, spi_out out) that the sensor_spi master drives.
- Oversamples all SPI lines in the clk_fix domain.
- Decodes write and read frames and maintains a sensor register bank.
- Returns read data on spi_out.
- Used as the sensor stand-in on a loopback/bring-up build and as the reference model in sensor_spi regressions.

Parameters:
NUM_REGS, 32, number of 8-bit registers implemented (addresses 0..NUM_REGS-1); legal range 1..256
RST_VAL, 8'h00, reset value of every register
SYNC_STAGES, 2, synchronizer depth on spi_clk/spi_write/spi_read/spi_in; minimum 2

Ports:
clk_fix  in  1  system clock; all logic on rising edge
rst_fix_n  in  1  asynchronous active-low reset
spi_clk  in  1  SPI clock from master, asynchronous to clk_fix
spi_write  in  1  write frame enable, active high
spi_read  in  1  read frame enable, active high
spi_in  in  1  master-to-slave serial data, MSB first
spi_out  out  1  slave-to-master serial data, MSB first
reg_bank  out  NUM_REGS*8  flat register image; reg n at bits [8n+7:8n]
reg_wr_pulse  out  1  one-cycle pulse when a register is updated
reg_wr_addr  out  8  address of the last completed write
frame_err  out  1  one-cycle pulse on aborted or illegal frame

Behaviour:
- Clock and reset:
  - Single clock clk_fix.
  - Reset is asynchronous, active-low: rst_fix_n.
  - Reset values: reg_bank all RST_VAL, spi_out 0, reg_wr_pulse 0, reg_wr_addr 0, frame_err 0, FSM IDLE, shift/bit counters 0.
- Input sampling:
  - All four inputs pass through SYNC_STAGES flops.
  - Rise/fall detect on synchronized spi_clk compares the last sync stage with one extra delay flop.
  - spi_in is sampled from the synchronized value in the cycle the rise is detected.
- Timing constraint: spi_clk high and low phases are each >= 4 clk_fix periods. Faster clocks are out of spec; behaviour is undefined.
- Frame protocol:
  - Write frame: spi_write high for the frame; 16 rising edges: addr[7:0] then data[7:0].
  - Read frame: spi_read high for the frame; 8 rising edges carry addr[7:0], then 8 more clocks during which the slave drives data[7:0].
- FSM states:
  - IDLE: spi_out=0. Exactly one enable high -> ADDR (bit counter cleared, type latched). Both high -> frame_err pulse, go to ERR.
  - ADDR: shift spi_in on each rise. On the 8th rise, address latched; write -> WDATA, read -> RDATA.
  - WDATA: shift on each rise. On the 8th rise -> COMMIT.
  - COMMIT (one cycle):
    - If addr < NUM_REGS: register updated, reg_wr_pulse=1, reg_wr_addr=addr.
    - Otherwise no update, no pulse.
    - Then go to DONE.
  - RDATA:
    - Read data = reg[addr], or 8'h00 if addr >= NUM_REGS.
    - Load the shifter in the cycle after the 8th address rise; drive MSB on spi_out within 2 clk_fix cycles of that rise.
    - Each subsequent detected fall shifts the next bit out.
    - After the 8th data rise -> DONE. spi_out holds the LSB until the frame ends.
  - DONE: extra spi_clk edges are ignored. Enable deasserted -> IDLE, spi_out=0.
  - ERR: wait until both enables are low -> IDLE.
- Abort: the active enable dropping in ADDR, WDATA or RDATA:
  - frame_err pulse, no register update, spi_out=0, go to IDLE.
- Simultaneous events: enable deassert detected in the same cycle as the final (16th) rise counts as an abort; the frame is not committed.
- Ordering: a register read in the frame immediately after a write to the same address returns the new value, since COMMIT precedes any new frame.
- Reset mid-frame: everything returns to reset values, including reg_bank. The next frame requires the enable to be low for >= 1 synchronized sample first.

Decomposition:
- Shared package sensor_spi_pkg:
  - frame bit counts ADDR_BITS=8, DATA_BITS=8
  - FSM state encoding
  - constant READ_OOR_VAL=8'h00
- The same package is used by sensor_spi so master and responder agree on framing.
- One sub-module, spi_in_sync: SYNC_STAGES synchronizer plus spi_clk rise/fall detect, outputs sclk_rise, sclk_fall, wr_en_s, rd_en_s, sdi_s.

Test Plan:
- Reset, then write addr 0x05 data 0xA7 at spi_clk = clk_fix/10 -> reg_wr_pulse once, reg_wr_addr=0x05, reg_bank[47:40]=0xA7, all other regs 0x00.
- After that write, read addr 0x05 -> spi_out bits 1,0,1,0,0,1,1,1 sampled on the 8 master rising edges; spi_out=0 after spi_read falls.
- Write addr 0x40 (>= NUM_REGS=32) data 0xFF -> no reg_wr_pulse, reg_bank unchanged; then read 0x40 -> 0x00 shifted out.
- Write addr 0x03, drop spi_write after 11 bits -> frame_err pulse, reg 3 unchanged; next full write to 0x03 data 0x3C succeeds.
- spi_write and spi_read both high -> frame_err, no update; the responder ignores clocks until both are low, then the next read of reg 0 returns 0x00.
- Assert rst_fix_n low during WDATA of a write to 0x01 after 0x01 was set to 0x55 -> reg_bank returns to all 0x00, spi_out=0; a subsequent clean read of 0x01 returns 0x00.
